sim_mem_pipelined: RTL and testbench

- Parametrised, clocked successor of the combinational simulation memory; the CPU's instruction and data models instantiate it.
- Byte-addressed, word-organised storage with byte-masked writes.
- Valid/ready request and response channels, a fixed programmable latency and a bounded number of outstanding requests.
- Every request, read or write, returns exactly one in-order response. Out-of-range accesses are flagged instead of aliasing.

---
 rtl/sim_mem_pipelined.sv | 137 +++++++++++++
 tb/tb_sim_mem_pipelined.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_pipelined.sv
// Clocked simulation memory: byte-masked word storage behind valid/ready channels,
// a fixed response latency and a credit-bounded in-order response FIFO.
module sim_mem_pipelined #(
  parameter int unsigned DEPTH_LOG2      = 14,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_cmd,
  output logic        resp_err
);

  localparam int unsigned Words  = 2 ** DEPTH_LOG2;
  localparam int unsigned PtrW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned Stages = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        cmd;
    logic        err;
    logic        valid;
  } entry_t;

  logic [31:0] mem [Words];

  logic                  accept;
  logic                  pop;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  entry_t                new_entry;
  entry_t                push_entry;
  entry_t                pipe_q [Stages];
  entry_t                pipe_d [Stages];
  entry_t                fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [CntW-1:0]       out_q, out_d;

  assign word_idx   = req_addr[DEPTH_LOG2+1:2];
  assign in_range   = ((req_addr >> (DEPTH_LOG2 + 2)) == 32'd0);
  // Single counter of accepted-but-unpopped requests = delay-line occupancy + FIFO count.
  assign req_ready  = !reset && (out_q < CntW'(MAX_OUTSTANDING));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (fifo_cnt_q != '0);
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    new_entry.valid = accept;
    new_entry.cmd   = req_cmd;
    new_entry.err   = !in_range;
    new_entry.rdata = (accept && !req_cmd && in_range) ? mem[word_idx] : 32'd0;
  end

  // The accept edge itself counts as the first latency stage, so only LATENCY-1
  // registers sit between the request and the FIFO write.
  always_comb begin
    pipe_d[0] = new_entry;
    for (int i = 1; i < Stages; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    push_entry = (LATENCY == 1) ? new_entry : pipe_q[Stages-1];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_entry.valid) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    fifo_cnt_d = fifo_cnt_q + CntW'(push_entry.valid) - CntW'(pop);
    out_d      = out_q + CntW'(accept) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Stages; i++) begin
        pipe_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      for (int i = 0; i < Stages; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_q      <= out_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (!reset && push_entry.valid) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_cmd && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b]) begin
          mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    resp_rdata = 32'd0;
    resp_cmd   = 1'b0;
    resp_err   = 1'b0;
    if (resp_valid) begin
      resp_rdata = fifo_q[rd_ptr_q].rdata;
      resp_cmd   = fifo_q[rd_ptr_q].cmd;
      resp_err   = fifo_q[rd_ptr_q].err;
    end
  end

endmodule

// File: tb/tb_sim_mem_pipelined.sv
// Scoreboard bench for sim_mem_pipelined: requests push expected responses,
// a negedge monitor pops and compares each response the DUT hands over.
module tb_sim_mem_pipelined;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_cmd = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_mask = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_cmd;
  logic        resp_err;

  sim_mem_pipelined #(
    .DEPTH_LOG2      (14),
    .LATENCY         (Lat),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_cmd   (resp_cmd),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        cmd;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid && ready here.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && resp_valid && resp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got rdata=%h cmd=%b err=%b, required no response",
                   resp_rdata, resp_cmd, resp_err);
        end else begin
          mon_e = sb.pop_front();
          if ({resp_rdata, resp_cmd, resp_err} !== {mon_e.rdata, mon_e.cmd, mon_e.err}) begin
            fails++;
            $display("FAIL resp_data: got rdata=%h cmd=%b err=%b, required rdata=%h cmd=%b err=%b",
                     resp_rdata, resp_cmd, resp_err, mon_e.rdata, mon_e.cmd, mon_e.err);
          end
          if (mon_e.exp_cyc >= 0) begin
            tests++;
            if (cyc != mon_e.exp_cyc) begin
              fails++;
              $display("FAIL resp_latency: got cycle %0d, required cycle %0d", cyc, mon_e.exp_cyc);
            end
          end
        end
      end
    end
  end

  // Entered and left at posedge+1; pushes the expectation at the accept edge.
  task automatic send(input logic cmd, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input bit lat_chk);
    bit   got;
    exp_t e;
    got       = 1'b0;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_mask  = mask;
    req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    req_valid = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept for addr %h, required accept", addr);
    end else begin
      e.rdata   = exp_rdata;
      e.cmd     = cmd;
      e.err     = exp_err;
      e.exp_cyc = lat_chk ? cyc + Lat - 1 : -1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  logic [31:0] bp_addr [6] = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30};
  logic [31:0] bp_data [6] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h5,
                               32'hDEADBEEF, 32'h11BB33DD, 32'h5};

  initial begin
    int   acc;
    int   idx;
    bit   rdy;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_cmd", 32'(resp_cmd), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic write then read, back to back
    send(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte mask, including an all-zero mask
    send(1'b1, 32'h20, 4'hF, 32'h11223344, 32'd0, 1'b0, 1'b0);
    send(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0, 1'b1);
    send(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0, 1'b1);

    // Read-after-write in consecutive cycles
    send(1'b1, 32'h30, 4'hF, 32'h5, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'h30, 4'h0, 32'd0, 32'h5, 1'b0, 1'b1);

    // Out of range: flagged, no aliasing onto word 0
    send(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    send(1'b1, 32'h00010000, 4'hF, 32'h1, 32'd0, 1'b1, 1'b0);
    send(1'b0, 32'h00010000, 4'h0, 32'd0, 32'd0, 1'b1, 1'b1);
    send(1'b0, 32'h0, 4'h0, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_drain();

    // Backpressure and credits
    resp_ready = 1'b0;
    acc = 0;
    idx = 0;
    req_valid = 1'b1;
    req_cmd   = 1'b0;
    req_mask  = 4'h0;
    req_addr  = bp_addr[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        e.rdata   = bp_data[idx];
        e.cmd     = 1'b0;
        e.err     = 1'b0;
        e.exp_cyc = -1;
        sb.push_back(e);
        acc++;
        idx++;
        if (idx < 6) req_addr = bp_addr[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready_full", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_hold_valid", 32'(resp_valid), 32'd1);
    chk("bp_hold_rdata0", resp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_hold_rdata1", resp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_same_cycle", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("bp_ready_after_pop", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("bp_next_rdata", resp_rdata, 32'h11BB33DD);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_drain();

    // Reset mid-flight; a write offered during reset must not land
    resp_ready = 1'b0;
    send(1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    send(1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0, 1'b0);
    send(1'b0, 32'h30, 4'h0, 32'd0, 32'h5, 1'b0, 1'b0);
    sb.delete();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_cmd   = 1'b1;
    req_addr  = 32'h10;
    req_mask  = 4'hF;
    req_wdata = 32'd0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    send(1'b0, 32'h30, 4'h0, 32'd0, 32'h5, 1'b0, 1'b1);
    wait_drain();
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
